// File: rtl/btn_hex_counter.sv
// Three debounced push-buttons (inc, dec, load) driving an 8-bit value for the
// two-digit hex display scanner, plus a one-cycle wrap pulse.

module btn_hex_counter_db #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_ev
);

    localparam logic [23:0] TERM = 24'(DB_CYCLES - 1);

    logic        r_sync_p0;
    logic        r_sync_p1;
    logic [23:0] r_dcnt;
    logic        r_db;
    logic        r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_dcnt    <= 24'd0;
            r_db      <= 1'b0;
            r_prev    <= 1'b0;
        end else begin
            // two-flop synchronizer for the asynchronous button
            r_sync_p0 <= i_btn;
            r_sync_p1 <= r_sync_p0;
            r_prev    <= r_db;
            // any sample agreeing with the debounced state restarts the count
            if (r_sync_p1 == r_db) begin
                r_dcnt <= 24'd0;
            end else if (r_dcnt == TERM) begin
                r_db   <= r_sync_p1;
                r_dcnt <= 24'd0;
            end else begin
                r_dcnt <= r_dcnt + 24'd1;
            end
        end
    end

    // press event only; release is debounced but silent
    assign o_ev = r_db & ~r_prev;

endmodule

module btn_hex_counter #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_ld,
    input  logic [7:0] sw,
    output logic [7:0] cnt,
    output logic       wrap
);

    logic       w_ev_inc;
    logic       w_ev_dec;
    logic       w_ev_ld;
    logic [7:0] r_cnt;
    logic       r_wrap;

    btn_hex_counter_db #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .i_btn (btn_inc),
        .o_ev  (w_ev_inc)
    );

    btn_hex_counter_db #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
        .clk   (clk),
        .rst   (rst),
        .i_btn (btn_dec),
        .o_ev  (w_ev_dec)
    );

    btn_hex_counter_db #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
        .clk   (clk),
        .rst   (rst),
        .i_btn (btn_ld),
        .o_ev  (w_ev_ld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= 8'h00;
            r_wrap <= 1'b0;
        end else if (w_ev_ld) begin
            // load wins and swallows any coincident inc/dec
            r_cnt  <= sw;
            r_wrap <= 1'b0;
        end else if (w_ev_inc && w_ev_dec) begin
            r_wrap <= 1'b0;
        end else if (w_ev_inc) begin
            r_cnt  <= r_cnt + 8'd1;
            r_wrap <= (r_cnt == 8'hFF);
        end else if (w_ev_dec) begin
            r_cnt  <= r_cnt - 8'd1;
            r_wrap <= (r_cnt == 8'h00);
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign cnt  = r_cnt;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_btn_hex_counter.sv
// Bench for btn_hex_counter: directed scenarios then random button activity,
// compared every cycle against a sample-window reference model.

module tb_btn_hex_counter;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_ld = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] cnt;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    btn_hex_counter #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_inc (btn_inc),
        .btn_dec (btn_dec),
        .btn_ld  (btn_ld),
        .sw      (sw),
        .cnt     (cnt),
        .wrap    (wrap)
    );

    // Reference: a button's debounced state flips once the DB most recent
    // synchronized samples (raw samples delayed by two edges) all disagree with it.
    logic [7:0]  m_cnt;
    logic        m_wrap;
    logic [2:0]  m_db;
    logic [2:0]  m_prev;
    logic [63:0] m_hist [3];

    always @(posedge clk) begin
        logic [2:0]  b;
        logic [2:0]  ev;
        logic [2:0]  ndb;
        logic [63:0] mask;
        int          nc;
        logic        nw;
        b    = {btn_ld, btn_dec, btn_inc};
        mask = ((64'd1 << DB) - 64'd1) << 1;
        if (rst) begin
            m_cnt  <= 8'h00;
            m_wrap <= 1'b0;
            m_db   <= 3'b000;
            m_prev <= 3'b000;
            for (int i = 0; i < 3; i++) m_hist[i] <= 64'd0;
        end else begin
            ev = m_db & ~m_prev;
            nc = int'(m_cnt);
            nw = 1'b0;
            if (ev[2]) begin
                nc = int'(sw);
            end else if (ev[0] && ev[1]) begin
                nw = 1'b0;
            end else if (ev[0]) begin
                nc = int'(m_cnt) + 1;
                nw = (nc == 256);
                nc = nc % 256;
            end else if (ev[1]) begin
                nc = int'(m_cnt) - 1;
                nw = (nc < 0);
                nc = (nc + 256) % 256;
            end
            m_cnt  <= 8'(nc);
            m_wrap <= nw;
            for (int i = 0; i < 3; i++) begin
                ndb[i] = ((m_hist[i] & mask) == (m_db[i] ? 64'd0 : mask)) ? ~m_db[i] : m_db[i];
                m_hist[i] <= {m_hist[i][62:0], b[i]};
            end
            m_prev <= m_db;
            m_db   <= ndb;
        end
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        @(negedge clk);
        check8({tag, ":cnt"}, cnt, m_cnt);
        check8({tag, ":wrap"}, {7'd0, wrap}, {7'd0, m_wrap});
    endtask

    task automatic ticks(input string tag, input int n);
        repeat (n) tick(tag);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout cnt=%02h", cnt);
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        ticks("rst", 3);
        check8("rst_cnt", cnt, 8'h00);
        check8("rst_wrap", {7'd0, wrap}, 8'h00);
        rst = 1'b0;
        ticks("idle", 5);

        // single held press: one increment six edges after first sampling edge
        btn_inc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick("t1");
            check8("t1_before", cnt, 8'h00);
        end
        tick("t1");
        check8("t1_inc", cnt, 8'h01);
        check8("t1_wrap", {7'd0, wrap}, 8'h00);
        ticks("t1_hold", 50);
        check8("t1_norepeat", cnt, 8'h01);
        btn_inc = 1'b0;
        ticks("t1_rel", 10);

        // bounce: short high runs, then a solid hold
        btn_inc = 1'b1; ticks("t2", 3);
        btn_inc = 1'b0; ticks("t2", 1);
        btn_inc = 1'b1; ticks("t2", 3);
        btn_inc = 1'b0; ticks("t2", 1);
        btn_inc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick("t2");
            check8("t2_before", cnt, 8'h01);
        end
        tick("t2");
        check8("t2_inc", cnt, 8'h02);
        btn_inc = 1'b0; ticks("t2_rel", 10);
        btn_inc = 1'b1; ticks("t2_short", 3);
        btn_inc = 1'b0; ticks("t2_short", 10);
        check8("t2_short", cnt, 8'h02);

        // wrap up and down
        sw = 8'hFF;
        btn_ld = 1'b1; ticks("t3_ld", 8);
        btn_ld = 1'b0; ticks("t3_ld", 8);
        check8("t3_load", cnt, 8'hFF);
        btn_inc = 1'b1; ticks("t3_inc", 6);
        tick("t3_inc");
        check8("t3_inc_cnt", cnt, 8'h00);
        check8("t3_inc_wrap", {7'd0, wrap}, 8'h01);
        tick("t3_inc");
        check8("t3_inc_wrap_end", {7'd0, wrap}, 8'h00);
        btn_inc = 1'b0; ticks("t3_rel", 8);
        btn_dec = 1'b1; ticks("t3_dec", 6);
        tick("t3_dec");
        check8("t3_dec_cnt", cnt, 8'hFF);
        check8("t3_dec_wrap", {7'd0, wrap}, 8'h01);
        tick("t3_dec");
        check8("t3_dec_wrap_end", {7'd0, wrap}, 8'h00);
        btn_dec = 1'b0; ticks("t3_rel", 8);

        // simultaneous events
        btn_inc = 1'b1; btn_dec = 1'b1; ticks("t4", 7);
        check8("t4_incdec_cnt", cnt, 8'hFF);
        check8("t4_incdec_wrap", {7'd0, wrap}, 8'h00);
        btn_inc = 1'b0; btn_dec = 1'b0; ticks("t4_rel", 8);
        sw = 8'h5A;
        btn_inc = 1'b1; btn_dec = 1'b1; btn_ld = 1'b1; ticks("t4", 7);
        check8("t4_ld_all", cnt, 8'h5A);
        btn_inc = 1'b0; btn_dec = 1'b0; btn_ld = 1'b0; ticks("t4_rel", 8);

        // reset while a press is debouncing; held button counts as a new press
        btn_dec = 1'b1; ticks("t5", 2);
        rst = 1'b1; ticks("t5_rst", 3);
        check8("t5_rst_cnt", cnt, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick("t5");
            check8("t5_before", cnt, 8'h00);
        end
        tick("t5");
        check8("t5_dec_cnt", cnt, 8'hFF);
        check8("t5_dec_wrap", {7'd0, wrap}, 8'h01);
        btn_dec = 1'b0; ticks("t5_rel", 8);

        // repeated press/release, then sw wiggles with load idle
        rst = 1'b1; tick("t6_rst");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            btn_inc = 1'b1; ticks("t6", 7);
            btn_inc = 1'b0; ticks("t6", 8);
        end
        check8("t6_five", cnt, 8'h05);
        for (int i = 0; i < 10; i++) begin
            sw = 8'($urandom);
            tick("t6_sw");
        end
        check8("t6_sw_idle", cnt, 8'h05);

        // random activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) btn_inc = ~btn_inc;
            if ($urandom_range(0, 11) == 0) btn_dec = ~btn_dec;
            if ($urandom_range(0, 15) == 0) btn_ld = ~btn_ld;
            sw  = 8'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
